// File: rtl/game_pkg.sv
// Shared game-core package: playfield bounds, obstacle count, game modes.
// Imported by the obstacle generator and the player/collision block.
package game_pkg;

   localparam int UPPER_BOUND    = 20;
   localparam int LOWER_BOUND    = 460;
   localparam int PLAYER_X_LEFT  = 160;
   localparam int PLAYER_X_RIGHT = 200;
   localparam int N_OBSTACLES    = 10;

   typedef enum logic [1:0] {
      GM_CLEAR = 2'b00,
      GM_RUN   = 2'b01,
      GM_PAUSE = 2'b10,
      GM_CRASH = 2'b11
   } gamemode_t;

   function automatic logic [9:0] sat_add(
      input logic [9:0] a,
      input logic [2:0] b
   );
      logic [10:0] s;
      s = {1'b0, a} + {8'd0, b};
      return (s > 11'd999) ? 10'd999 : s[9:0];
   endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, taps 15/13/12/10.
// Only reset reloads the seed.
module lfsr16 #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [15:0] q
);

   logic fb;

   assign fb = q[15] ^ q[13] ^ q[12] ^ q[10];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) q <= SEED;
      else        q <= {q[14:0], fb};
   end

endmodule

// File: rtl/obstacle_gen.sv
// Obstacle generator: spawns, scrolls and retires column pairs,
// keeps the pass score and derives the scroll speed from it.
module obstacle_gen
   import game_pkg::*;
#(
   parameter int          N_COLS         = 5,
   parameter int          SPAWN_X        = 640,
   parameter int          COL_WIDTH      = 40,
   parameter int          GAP_SIZE       = 120,
   parameter int          GAP_TOP_MIN    = 60,
   parameter int          FIRST_DELAY    = 30,
   parameter int          SPAWN_INTERVAL = 90,
   parameter int          BASE_SPEED     = 2,
   parameter int          MAX_SPEED      = 8,
   parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [1:0]                gamemode,
   output logic [2*N_COLS-1:0][9:0]  obstacle_x_left,
   output logic [2*N_COLS-1:0][9:0]  obstacle_x_right,
   output logic [2*N_COLS-1:0][8:0]  obstacle_y_up,
   output logic [2*N_COLS-1:0][8:0]  obstacle_y_down,
   output logic [9:0]                score,
   output logic [3:0]                scroll_speed
);

   localparam int PTR_W = (N_COLS > 1) ? $clog2(N_COLS) : 1;
   localparam int T_MAX = (FIRST_DELAY > SPAWN_INTERVAL) ?
                          FIRST_DELAY : SPAWN_INTERVAL;
   localparam int TMR_W = $clog2(T_MAX + 1);

   gamemode_t gm;

   logic [N_COLS-1:0]       act_q, act_d;
   logic [N_COLS-1:0]       pas_q, pas_d;
   logic [N_COLS-1:0][9:0]  xl_q, xl_d;
   logic [N_COLS-1:0][9:0]  xr_q, xr_d;
   logic [N_COLS-1:0][8:0]  gt_q, gt_d;
   logic [N_COLS-1:0][8:0]  gb_q, gb_d;
   logic [9:0]              score_q, score_d;
   logic [TMR_W-1:0]        tmr_q, tmr_d;
   logic [PTR_W-1:0]        ptr_q, ptr_d;
   logic [15:0]             lfsr_q;
   logic                    lfsr_unused;
   logic [7:0]              spd_raw;
   logic [3:0]              spd;
   logic [9:0]              s10;
   logic [8:0]              gap;
   logic [2:0]              npass;

   assign gm = gamemode_t'(gamemode);

   lfsr16 #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .q     (lfsr_q)
   );

   // Only the low byte feeds the gap draw.
   assign lfsr_unused = ^lfsr_q[15:8];

   assign spd_raw = 8'(BASE_SPEED) + {1'b0, score_q[9:3]};
   assign spd     = (spd_raw > 8'(MAX_SPEED)) ?
                    4'(MAX_SPEED) : spd_raw[3:0];
   assign s10     = {6'd0, spd};
   assign gap     = 9'(GAP_TOP_MIN) + {1'b0, lfsr_q[7:0]};

   always_comb begin
      act_d   = act_q;
      pas_d   = pas_q;
      xl_d    = xl_q;
      xr_d    = xr_q;
      gt_d    = gt_q;
      gb_d    = gb_q;
      score_d = score_q;
      tmr_d   = tmr_q;
      ptr_d   = ptr_q;
      npass   = '0;
      unique case (gm)
         GM_CLEAR: begin
            act_d   = '0;
            pas_d   = '0;
            xl_d    = '0;
            xr_d    = '0;
            gt_d    = '0;
            gb_d    = '0;
            score_d = '0;
            tmr_d   = TMR_W'(FIRST_DELAY);
            ptr_d   = '0;
         end
         GM_RUN: begin
            for (int k = 0; k < N_COLS; k++) begin
               if (act_q[k]) begin
                  if (xr_q[k] <= s10) begin
                     act_d[k] = 1'b0;
                     pas_d[k] = 1'b0;
                     xl_d[k]  = '0;
                     xr_d[k]  = '0;
                     gt_d[k]  = '0;
                     gb_d[k]  = '0;
                  end else begin
                     xr_d[k] = xr_q[k] - s10;
                     xl_d[k] = (xl_q[k] > s10) ? xl_q[k] - s10 : '0;
                     if (!pas_q[k] &&
                         xr_d[k] < 10'(PLAYER_X_LEFT)) begin
                        pas_d[k] = 1'b1;
                        npass    = npass + 3'd1;
                     end
                  end
               end
            end
            score_d = sat_add(score_q, npass);
            // Eligibility uses the registered flag: a column
            // retiring this frame cannot be refilled yet.
            if (tmr_q == '0) begin
               tmr_d = TMR_W'(SPAWN_INTERVAL - 1);
               if (!act_q[ptr_q]) begin
                  act_d[ptr_q] = 1'b1;
                  pas_d[ptr_q] = 1'b0;
                  xl_d[ptr_q]  = 10'(SPAWN_X);
                  xr_d[ptr_q]  = 10'(SPAWN_X + COL_WIDTH);
                  gt_d[ptr_q]  = gap;
                  gb_d[ptr_q]  = gap + 9'(GAP_SIZE);
                  ptr_d = (ptr_q == PTR_W'(N_COLS - 1)) ?
                          '0 : ptr_q + PTR_W'(1);
               end
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
         GM_PAUSE, GM_CRASH: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_q   <= '0;
         pas_q   <= '0;
         xl_q    <= '0;
         xr_q    <= '0;
         gt_q    <= '0;
         gb_q    <= '0;
         score_q <= '0;
         tmr_q   <= TMR_W'(FIRST_DELAY);
         ptr_q   <= '0;
      end else begin
         act_q   <= act_d;
         pas_q   <= pas_d;
         xl_q    <= xl_d;
         xr_q    <= xr_d;
         gt_q    <= gt_d;
         gb_q    <= gb_d;
         score_q <= score_d;
         tmr_q   <= tmr_d;
         ptr_q   <= ptr_d;
      end
   end

   for (genvar k = 0; k < N_COLS; k++) begin : g_slot
      assign obstacle_x_left[2*k]    = xl_q[k];
      assign obstacle_x_left[2*k+1]  = xl_q[k];
      assign obstacle_x_right[2*k]   = xr_q[k];
      assign obstacle_x_right[2*k+1] = xr_q[k];
      assign obstacle_y_up[2*k]      = act_q[k] ? 9'(UPPER_BOUND) : '0;
      assign obstacle_y_down[2*k]    = gt_q[k];
      assign obstacle_y_up[2*k+1]    = gb_q[k];
      assign obstacle_y_down[2*k+1]  = act_q[k] ? 9'(LOWER_BOUND) : '0;
   end

   assign score        = score_q;
   assign scroll_speed = spd;

endmodule

// File: tb/tb_obstacle_gen.sv
// Scoreboard bench for obstacle_gen: default instance plus a
// short-interval instance for the full-occupancy case.
module tb_obstacle_gen;
   import game_pkg::*;

   typedef struct packed {
      logic [4:0]       act;
      logic [4:0]       pas;
      logic [4:0][9:0]  xl;
      logic [4:0][9:0]  xr;
      logic [4:0][8:0]  g;
      logic [9:0]       score;
      logic [6:0]       timer;
      logic [2:0]       ptr;
      logic [15:0]      lfsr;
   } mst_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic [1:0] gm_a, gm_b;
   logic [9:0][9:0] xl_a, xr_a, xl_b, xr_b;
   logic [9:0][8:0] yu_a, yd_a, yu_b, yd_b;
   logic [9:0] sc_a, sc_b;
   logic [3:0] sp_a, sp_b;
   logic [393:0] oa, ob;

   assign oa = {xl_a, xr_a, yu_a, yd_a, sc_a, sp_a};
   assign ob = {xl_b, xr_b, yu_b, yd_b, sc_b, sp_b};

   obstacle_gen dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .gamemode         (gm_a),
      .obstacle_x_left  (xl_a),
      .obstacle_x_right (xr_a),
      .obstacle_y_up    (yu_a),
      .obstacle_y_down  (yd_a),
      .score            (sc_a),
      .scroll_speed     (sp_a)
   );

   obstacle_gen #(
      .SPAWN_INTERVAL (10)
   ) dut_f (
      .clk              (clk),
      .rst_n            (rst_n),
      .gamemode         (gm_b),
      .obstacle_x_left  (xl_b),
      .obstacle_x_right (xr_b),
      .obstacle_y_up    (yu_b),
      .obstacle_y_down  (yd_b),
      .score            (sc_b),
      .scroll_speed     (sp_b)
   );

   mst_t ma, mb;
   logic [393:0] qa[$];
   logic [393:0] qb[$];
   int n_chk = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [393:0] obs,
                        input logic [393:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
   endtask

   function automatic mst_t mreset();
      mst_t m;
      m = '0;
      m.timer = 7'd30;
      m.lfsr = 16'hACE1;
      return m;
   endfunction

   function automatic int mspeed(input logic [9:0] sc);
      int v;
      v = 2 + int'(sc) / 8;
      return (v > 8) ? 8 : v;
   endfunction

   function automatic mst_t mstep(input mst_t m, input logic [1:0] gm,
                                  input int intv);
      mst_t n;
      int s, inc, sc;
      n = m;
      n.lfsr = {m.lfsr[14:0],
                m.lfsr[15] ^ m.lfsr[13] ^ m.lfsr[12] ^ m.lfsr[10]};
      if (gm == 2'b00) begin
         n.act = '0; n.pas = '0; n.xl = '0; n.xr = '0; n.g = '0;
         n.score = '0; n.ptr = '0; n.timer = 7'd30;
      end else if (gm == 2'b01) begin
         s = mspeed(m.score);
         inc = 0;
         for (int k = 0; k < 5; k++) begin
            if (m.act[k]) begin
               if (int'(m.xr[k]) <= s) begin
                  n.act[k] = 1'b0; n.pas[k] = 1'b0;
                  n.xl[k] = '0; n.xr[k] = '0; n.g[k] = '0;
               end else begin
                  n.xr[k] = 10'(int'(m.xr[k]) - s);
                  n.xl[k] = (int'(m.xl[k]) > s) ?
                            10'(int'(m.xl[k]) - s) : 10'd0;
                  if (!m.pas[k] && int'(m.xr[k]) - s < 160) begin
                     n.pas[k] = 1'b1;
                     inc++;
                  end
               end
            end
         end
         sc = int'(m.score) + inc;
         n.score = 10'((sc > 999) ? 999 : sc);
         if (m.timer == 0) begin
            n.timer = 7'(intv - 1);
            if (!m.act[m.ptr]) begin
               n.act[m.ptr] = 1'b1;
               n.pas[m.ptr] = 1'b0;
               n.xl[m.ptr] = 10'd640;
               n.xr[m.ptr] = 10'd680;
               n.g[m.ptr] = 9'(60 + int'(m.lfsr[7:0]));
               n.ptr = (m.ptr == 3'd4) ? 3'd0 : m.ptr + 3'd1;
            end
         end else begin
            n.timer = m.timer - 7'd1;
         end
      end
      return n;
   endfunction

   function automatic logic [393:0] mexp(input mst_t m);
      logic [9:0][9:0] xl, xr;
      logic [9:0][8:0] yu, yd;
      for (int k = 0; k < 5; k++) begin
         xl[2*k] = m.xl[k];  xl[2*k+1] = m.xl[k];
         xr[2*k] = m.xr[k];  xr[2*k+1] = m.xr[k];
         yu[2*k]   = m.act[k] ? 9'd20 : 9'd0;
         yd[2*k]   = m.act[k] ? m.g[k] : 9'd0;
         yu[2*k+1] = m.act[k] ? 9'(m.g[k] + 9'd120) : 9'd0;
         yd[2*k+1] = m.act[k] ? 9'd460 : 9'd0;
      end
      return {xl, xr, yu, yd, m.score, 4'(mspeed(m.score))};
   endfunction

   task automatic tick(input logic [1:0] a, input logic [1:0] b);
      gm_a = a;
      gm_b = b;
      ma = mstep(ma, a, 90);
      mb = mstep(mb, b, 10);
      qa.push_back(mexp(ma));
      qb.push_back(mexp(mb));
      @(posedge clk);
      #1;
      check("cycle_a", oa, qa.pop_front());
      check("cycle_b", ob, qb.pop_front());
   endtask

   task automatic run(input int n, input logic [1:0] a,
                      input logic [1:0] b);
      for (int i = 0; i < n; i++) tick(a, b);
   endtask

   initial begin
      logic [8:0] g0;
      rst_n = 1'b0;
      gm_a = GM_CLEAR;
      gm_b = GM_CLEAR;
      ma = mreset();
      mb = mreset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_out", oa, mexp(ma));
      check("rst_lfsr", dut.lfsr_q, 16'hACE1);
      check("rst_speed", sp_a, 4'd2);
      @(negedge clk);
      rst_n = 1'b1;

      tick(GM_CLEAR, GM_CLEAR);
      check("lfsr_first", dut.lfsr_q, 16'h59C3);

      run(30, GM_RUN, GM_CLEAR);
      check("pre_spawn", {xl_a, xr_a}, '0);
      g0 = 9'(60 + int'(ma.lfsr[7:0]));
      tick(GM_RUN, GM_CLEAR);
      check("spawn_xl", {xl_a[1], xl_a[0]}, {10'd640, 10'd640});
      check("spawn_xr", {xr_a[1], xr_a[0]}, {10'd680, 10'd680});
      check("spawn_top", {yu_a[0], yd_a[0]}, {9'd20, g0});
      check("spawn_bot", {yu_a[1], yd_a[1]}, {9'(g0 + 9'd120), 9'd460});
      check("spawn_rest", {xl_a[9:2], xr_a[9:2], yu_a[9:2], yd_a[9:2]}, '0);

      run(261, GM_RUN, GM_CLEAR);
      check("pass_xr", xr_a[0], 10'd158);
      check("pass_score", sc_a, 10'd1);
      check("pass_speed", sp_a, 4'd2);
      run(78, GM_RUN, GM_CLEAR);
      check("pre_retire", xr_a[0], 10'd2);
      tick(GM_RUN, GM_CLEAR);
      check("retire", {xl_a[1:0], xr_a[1:0], yu_a[1:0], yd_a[1:0]}, '0);

      run(50, GM_PAUSE, GM_CLEAR);
      run(50, GM_CRASH, GM_CLEAR);
      run(200, GM_RUN, GM_CLEAR);

      force dut.score_q = 10'd15;
      ma.score = 10'd15;
      #1;
      release dut.score_q;
      #1;
      check("force15", sc_a, 10'd15);
      check("speed3", sp_a, 4'd3);
      for (int i = 0; i < 400 && sc_a == 10'd15; i++) tick(GM_RUN, GM_CLEAR);
      check("score16", sc_a, 10'd16);
      check("speed4", sp_a, 4'd4);

      force dut.score_q = 10'd999;
      ma.score = 10'd999;
      #1;
      release dut.score_q;
      #1;
      check("speed_max", sp_a, 4'd8);
      run(200, GM_RUN, GM_CLEAR);
      check("score_sat", sc_a, 10'd999);
      check("speed_sat", sp_a, 4'd8);

      run(30, GM_PAUSE, GM_RUN);
      tick(GM_PAUSE, GM_RUN);
      check("f_spawn0", xl_b[0], 10'd640);
      run(40, GM_PAUSE, GM_RUN);
      check("f_all", {xl_b[8], xl_b[0]}, {10'd640, 10'd560});
      check("f_ptr_wrap", dut_f.ptr_q, 3'd0);
      run(10, GM_PAUSE, GM_RUN);
      check("f_skip", {xl_b[8], xl_b[0]}, {10'd620, 10'd540});
      check("f_ptr_hold", dut_f.ptr_q, 3'd0);
      run(289, GM_PAUSE, GM_RUN);
      check("f_pre_ret", xr_b[0], 10'd2);
      tick(GM_PAUSE, GM_RUN);
      check("f_retire", {xl_b[0], xr_b[0]}, '0);
      check("f_ptr_ret", dut_f.ptr_q, 3'd0);
      run(10, GM_PAUSE, GM_RUN);
      check("f_refill", {xl_b[0], xr_b[0]}, {10'd640, 10'd680});
      check("f_ptr_adv", dut_f.ptr_q, 3'd1);

      run(5, GM_RUN, GM_RUN);
      #3;
      rst_n = 1'b0;
      ma = mreset();
      mb = mreset();
      #1;
      check("async_a", oa, mexp(ma));
      check("async_b", ob, mexp(mb));
      check("async_lfsr", dut.lfsr_q, 16'hACE1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
